sram_arbiter: RTL

Two-port arbiter and sequencer for the external 16-bit asynchronous SRAM with active-low controls. It accepts word/byte requests from two masters over a simple cyc/we/ack handshake: port 0 is the CPU, port 1 is DMA/video. Requests are granted round-robin, and each one is sequenced as a fixed-length SRAM cycle driving ncs/noe/nwe, address, byte selects and write data. Read data is registered and returned with a one-cycle ack.

---
 rtl/sram_pkg.sv | 20 ++
 rtl/sram_arbiter_if.sv | 25 ++
 rtl/rr_arb2.sv | 31 +++
 rtl/sram_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_pkg;

    localparam int DATA_W = 16;
    localparam int BSEL_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        ACK
    } state_t;

    // Lanes that were not selected read back as zero so masters never see stale bytes.
    function automatic logic [DATA_W-1:0] lane_mask(input logic [DATA_W-1:0] data,
                                                    input logic [BSEL_W-1:0] sel);
        return {sel[1] ? data[15:8] : 8'h00, sel[0] ? data[7:0] : 8'h00};
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Per-master request bus: cyc/we handshake with word address, byte selects and data.
interface sram_arbiter_if #(
    parameter int AB_WIDTH = 16
);
    import sram_pkg::*;

    logic                cyc;
    logic                we;
    logic [AB_WIDTH-1:0] adr;
    logic [BSEL_W-1:0]   sel;
    logic [DATA_W-1:0]   wdat;
    logic [DATA_W-1:0]   rdat;
    logic                ack;

    modport master (
        output cyc, we, adr, sel, wdat,
        input  rdat, ack
    );

    modport slave (
        input  cyc, we, adr, sel, wdat,
        output rdat, ack
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; on a tie the port that did not win last time is granted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Reset to 1 so port 0 takes the very first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (en && (req != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two masters onto one asynchronous 16-bit SRAM and sequences each
// access as IDLE -> SETUP -> ACCESS (WAIT_CYCLES+1) -> ACK with registered strobes.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int AB_WIDTH    = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sram_arbiter_if.slave       m0,
    sram_arbiter_if.slave       m1,
    output logic [AB_WIDTH-1:0] sram_addr_o,
    output logic [BSEL_W-1:0]   sram_bsel_o,
    output logic [DATA_W-1:0]   sram_dat_o,
    input  logic [DATA_W-1:0]   sram_dat_i,
    output logic                sram_ncs_o,
    output logic                sram_noe_o,
    output logic                sram_nwe_o
);

    state_t              state;
    state_t              state_next;
    logic [3:0]          cnt;
    logic                gnt_port;
    logic                we_r;
    logic [DATA_W-1:0]   rdata;
    logic                ack0;
    logic                ack1;
    logic [1:0]          grant;
    logic                grant_en;

    assign grant_en = (state == IDLE);

    rr_arb2 u_arb (
        .clk   (clk_i),
        .rst   (rst_i),
        .req   ({m1.cyc, m0.cyc}),
        .en    (grant_en),
        .grant (grant)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (m0.cyc || m1.cyc) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (cnt == 4'd0) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Every SRAM pin comes straight from a flop; strobes are decoded from the
    // next state so they change on the same edge as the state itself.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_port    <= 1'b0;
            we_r        <= 1'b0;
            sram_addr_o <= '0;
            sram_bsel_o <= '0;
            sram_dat_o  <= '0;
            cnt         <= 4'd0;
            rdata       <= '0;
            sram_ncs_o  <= 1'b1;
            sram_noe_o  <= 1'b1;
            sram_nwe_o  <= 1'b1;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
        end else begin
            if (state == IDLE && grant != 2'b00) begin
                gnt_port    <= grant[1];
                we_r        <= grant[1] ? m1.we   : m0.we;
                sram_addr_o <= grant[1] ? m1.adr  : m0.adr;
                sram_bsel_o <= grant[1] ? m1.sel  : m0.sel;
                sram_dat_o  <= grant[1] ? m1.wdat : m0.wdat;
            end

            if (state == SETUP) begin
                cnt <= 4'(WAIT_CYCLES);
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            if (state == ACCESS && cnt == 4'd0 && !we_r) begin
                rdata <= lane_mask(sram_dat_i, sram_bsel_o);
            end

            sram_ncs_o <= !(state_next == SETUP || state_next == ACCESS);
            sram_noe_o <= !(state_next == ACCESS && !we_r);
            sram_nwe_o <= !(state_next == ACCESS && we_r);
            ack0       <= (state_next == ACK) && !gnt_port;
            ack1       <= (state_next == ACK) && gnt_port;
        end
    end

    assign m0.ack  = ack0;
    assign m1.ack  = ack1;
    assign m0.rdat = rdata;
    assign m1.rdat = rdata;

endmodule
